instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_ack  input  1  instruction memory: imem_rdata valid this cycle.
REQ-005 imem_rdata  input  32  instruction word from memory.
REQ-006 Branch  input  1  from main controller: current instruction is BEQ.
REQ-007 Jump  input  1  from main controller: current instruction is J.
REQ-008 zero  input  1  from ALU: compare result equal.
REQ-009 stall  input  1  datapath not ready to retire current instruction.
REQ-010 imem_req  output  1  fetch request, held until ack.
REQ-011 imem_addr  output  32  fetch address, always equal to pc_out.
REQ-012 Inst_out  output  32  registered instruction to controller/datapath.
REQ-013 inst_valid  output  1  Inst_out holds a fetched, unretired instruction.
REQ-014 pc_out  output  32  address of current instruction.
REQ-015 state_out  output  2  FSM state encoding, for debug.

Function
REQ-016 FSM states: IDLE=2'b00, REQ=2'b01, HOLD=2'b10; 2'b11 unused, SHALL recover to IDLE next cycle.
REQ-017 IDLE: outputs inactive; unconditional transition to REQ next cycle.
REQ-018 REQ: imem_req=1, imem_addr=pc_out; on imem_ack=1, capture imem_rdata into Inst_out, go to HOLD; otherwise stay.
REQ-019 Ack in the same cycle imem_req first rises SHALL be accepted (zero-wait memory: 1 cycle in REQ).
REQ-020 imem_ack while not in REQ SHALL be ignored; Inst_out unchanged.
REQ-021 HOLD: inst_valid=1, imem_req=0; Inst_out and pc_out stable.
REQ-022 HOLD with stall=1: remain in HOLD, no PC update.
REQ-023 HOLD with stall=0: retire; load pc_out with next PC, go to REQ next cycle.
REQ-024 Next PC, pc4=pc_out+4 (mod 2^32): Jump=1 -> {pc4[31:28], Inst_out[25:0], 2'b00}; else Branch=1 and zero=1 -> pc4 + (sign-extended Inst_out[15:0] << 2), mod 2^32; else pc4.
REQ-025 Jump and Branch both 1: Jump wins.
REQ-026 Branch=1, zero=0: pc4.
REQ-027 PC wrap-around: 32'hFFFF_FFFC + 4 SHALL yield 32'h0000_0000, no error.
REQ-028 pc_out[1:0] SHALL always be 2'b00.
REQ-029 Branch/Jump/zero sampled only in retiring HOLD cycle; ignored elsewhere.
REQ-030 Latency: ack at edge N -> inst_valid=1 after edge N; retire at edge M -> imem_req=1 after edge M.

Reset
REQ-031 rst=1 SHALL immediately (no clock) force: state IDLE, pc_out=RESET_PC, Inst_out=0, inst_valid=0, imem_req=0, state_out=2'b00.
REQ-032 Reset mid-request SHALL abort the fetch; a late ack after reset release while in IDLE is ignored.
REQ-033 First fetch after rst release SHALL be from RESET_PC, imem_req rising 1 cycle after release (one IDLE cycle).

Structure
REQ-034 Shared package cpu_pkg: opcode constants (R, LW, SW, BEQ, J), fetch FSM state encoding, RESET_PC default.
REQ-035 One sub-module pc_next: combinational next-PC computation per REQ-024/025; FSM and registers stay in instr_fetch.

Verification
REQ-036 Reset release, ack same cycle as req, rdata=32'h8C01_0004, stall=0 -> imem_addr 0x0, then 0x4, 0x8; inst_valid one cycle per fetch.
REQ-037 PC=0x100, Inst_out=32'h1000_FFFE, Branch=1, zero=1 -> next imem_addr 0x0FC; same with zero=0 -> 0x104.
REQ-038 PC=0x4000_0010, Inst_out=32'h0800_0040, Jump=1, Branch=1 -> next imem_addr 0x4000_0100.
REQ-039 Ack delayed 3 cycles, then stall=1 for 4 cycles -> imem_req held 4 cycles, Inst_out/pc_out stable during stall, no PC advance.
REQ-040 rst asserted while imem_req=1 -> imem_req=0 and pc_out=RESET_PC before next edge; ack during IDLE ignored.
REQ-041 PC=32'hFFFF_FFFC, plain instruction, retire -> next imem_addr 32'h0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM encoding and default reset PC.
package cpu_pkg;

    localparam logic [5:0] OpR   = 6'h00;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpSw  = 6'h2B;
    localparam logic [5:0] OpBeq = 6'h04;
    localparam logic [5:0] OpJ   = 6'h02;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StHold = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC: jump target, taken BEQ target, or sequential pc+4.
module pc_next (
    input  logic [31:0] pc_i,
    input  logic [25:0] inst_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        zero_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] jump_target;

    assign pc4         = pc_i + 32'd4;
    assign br_off      = {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
    assign jump_target = {pc4[31:28], inst_i[25:0], 2'b00};

    // Jump takes priority over a simultaneous branch.
    always_comb begin
        next_pc_o = pc4;
        if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_i && zero_i) begin
            next_pc_o = pc4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests a word at pc_out, holds it until retired, then advances PC.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Inst_out,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [1:0]  state_out
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         req_q;
    logic         valid_q;
    logic [31:0]  next_pc;

    pc_next u_pc_next (
        .pc_i      (pc_q),
        .inst_i    (inst_q[25:0]),
        .branch_i  (Branch),
        .jump_i    (Jump),
        .zero_i    (zero),
        .next_pc_o (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            inst_q  <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                end
                StReq: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        state_q <= StHold;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        pc_q    <= next_pc;
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                // The spare encoding falls back to idle with outputs quiet.
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign Inst_out   = inst_q;
    assign inst_valid = valid_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: three instances with different RESET_PC share stimulus against a PC model.
module tb_instr_fetch;

    localparam int N = 3;
    localparam logic [31:0] RPC [N] = '{32'h0000_0000, 32'h4000_0010, 32'hFFFF_FFFC};

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Branch;
    logic        Jump;
    logic        zero;
    logic        stall;

    logic        req_w   [N];
    logic [31:0] addr_w  [N];
    logic [31:0] inst_w  [N];
    logic        valid_w [N];
    logic [31:0] pc_w    [N];
    logic [1:0]  st_w    [N];

    logic [31:0] exp_pc [N];
    logic [31:0] exp_inst;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        instr_fetch #(.RESET_PC(RPC[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .imem_ack   (imem_ack),
            .imem_rdata (imem_rdata),
            .Branch     (Branch),
            .Jump       (Jump),
            .zero       (zero),
            .stall      (stall),
            .imem_req   (req_w[g]),
            .imem_addr  (addr_w[g]),
            .Inst_out   (inst_w[g]),
            .inst_valid (valid_w[g]),
            .pc_out     (pc_w[g]),
            .state_out  (st_w[g])
        );
    end

    // Architectural next-PC rule written with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                               input bit br, input bit jp, input bit z);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
        if (br && z) begin
            off = int'($signed(inst[15:0])) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit req, input bit valid,
                               input logic [1:0] st);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.req[%0d]", tag, i), 32'(req_w[i]), 32'(req));
            chk($sformatf("%s.valid[%0d]", tag, i), 32'(valid_w[i]), 32'(valid));
            chk($sformatf("%s.state[%0d]", tag, i), 32'(st_w[i]), 32'(st));
            chk($sformatf("%s.pc[%0d]", tag, i), pc_w[i], exp_pc[i]);
            chk($sformatf("%s.addr[%0d]", tag, i), addr_w[i], exp_pc[i]);
            chk($sformatf("%s.inst[%0d]", tag, i), inst_w[i], exp_inst);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ctrl();
        Branch = 1'($urandom);
        Jump   = 1'($urandom);
        zero   = 1'($urandom);
    endtask

    // Expects the DUTs in the request state; performs one full fetch and retire.
    task automatic fetch_one(input logic [31:0] word, input int delay, input int nstall,
                             input bit br, input bit jp, input bit z);
        imem_ack = 1'b0;
        repeat (delay) begin
            imem_rdata = $urandom;
            rand_ctrl();
            tick();
            check_state("wait", 1'b1, 1'b0, 2'b01);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        stall      = 1'($urandom);
        rand_ctrl();
        tick();
        exp_inst = word;
        check_state("ack", 1'b0, 1'b1, 2'b10);
        repeat (nstall) begin
            stall      = 1'b1;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            rand_ctrl();
            tick();
            check_state("stall", 1'b0, 1'b1, 2'b10);
        end
        stall      = 1'b0;
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        Branch     = br;
        Jump       = jp;
        zero       = z;
        tick();
        for (int i = 0; i < N; i++) exp_pc[i] = model_next(exp_pc[i], exp_inst, br, jp, z);
        check_state("retire", 1'b1, 1'b0, 2'b01);
        imem_ack = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        zero     = 1'b0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) exp_pc[i] = RPC[i];
        exp_inst = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        zero       = 1'b0;
        stall      = 1'b0;
        reset_model();
        #1;
        check_state("rst_async", 1'b0, 1'b0, 2'b00);
        tick();
        tick();
        check_state("rst_hold", 1'b0, 1'b0, 2'b00);
        #2 rst = 1'b0;
        #1;
        check_state("post_release", 1'b0, 1'b0, 2'b00);
        tick();
        check_state("first_req", 1'b1, 1'b0, 2'b01);

        // Zero-wait memory, three sequential plain fetches; third instance wraps past 0xFFFFFFFC.
        repeat (3) fetch_one(32'h8C01_0004, 0, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a request, then a late ack while idle.
        imem_ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        reset_model();
        check_state("rst_midreq", 1'b0, 1'b0, 2'b00);
        imem_rdata = 32'hDEAD_BEEF;
        #2 rst = 1'b0;
        tick();
        check_state("late_ack", 1'b1, 1'b0, 2'b01);

        // Jump with branch also set: jump wins (0x40000010 -> 0x40000100 on instance 1).
        fetch_one(32'h0800_0040, 1, 0, 1'b1, 1'b1, 1'b1);
        chk("jump_target", addr_w[0], 32'h0000_0100);
        chk("jump_target_hi", addr_w[1], 32'h4000_0100);
        fetch_one(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("beq_taken", addr_w[0], 32'h0000_00FC);
        fetch_one(32'h0800_0040, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("jump_back", addr_w[0], 32'h0000_0100);
        fetch_one(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("beq_not_taken", addr_w[0], 32'h0000_0104);

        // Slow memory and a long stall.
        fetch_one(32'h0123_4567, 3, 4, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
